// File: rtl/port_prioritizer.sv
// Reorders up to three port requests into priority slots for the memory core,
// tagging each slot with its original port ID.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   rr_mode          0: fixed order 1>2>3, 1: rotating round-robin
//   portN_*_in       N=1..3 request valid/we/addr/data
//   in_ready         stage can capture this cycle (combinational)
//   out_ready        core consumes slots this cycle
//   slotN_*_out      N=1..3 registered slot valid/we/addr/data
//   slotN_orig_id    original port ID (1..3) of the request in slot N
//   conflict_drop    1-cycle pulse: a same-address write was dropped at capture
module port_prioritizer #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rr_mode,
  input  logic                  port1_valid_in,
  input  logic                  port1_we_in,
  input  logic [ADDR_WIDTH-1:0] port1_addr_in,
  input  logic [WIDTH-1:0]      port1_data_in,
  input  logic                  port2_valid_in,
  input  logic                  port2_we_in,
  input  logic [ADDR_WIDTH-1:0] port2_addr_in,
  input  logic [WIDTH-1:0]      port2_data_in,
  input  logic                  port3_valid_in,
  input  logic                  port3_we_in,
  input  logic [ADDR_WIDTH-1:0] port3_addr_in,
  input  logic [WIDTH-1:0]      port3_data_in,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  slot1_valid_out,
  output logic                  slot1_we_out,
  output logic [ADDR_WIDTH-1:0] slot1_addr_out,
  output logic [WIDTH-1:0]      slot1_data_out,
  output logic [1:0]            slot1_orig_id,
  output logic                  slot2_valid_out,
  output logic                  slot2_we_out,
  output logic [ADDR_WIDTH-1:0] slot2_addr_out,
  output logic [WIDTH-1:0]      slot2_data_out,
  output logic [1:0]            slot2_orig_id,
  output logic                  slot3_valid_out,
  output logic                  slot3_we_out,
  output logic [ADDR_WIDTH-1:0] slot3_addr_out,
  output logic [WIDTH-1:0]      slot3_data_out,
  output logic [1:0]            slot3_orig_id,
  output logic                  conflict_drop
);

  typedef enum logic [1:0] {
    RR_P1 = 2'd0,
    RR_P2 = 2'd1,
    RR_P3 = 2'd2
  } rr_t;

  rr_t rr_q;
  rr_t rr_next;

  logic [2:0]            p_valid;
  logic [2:0]            p_we;
  logic [ADDR_WIDTH-1:0] p_addr [3];
  logic [WIDTH-1:0]      p_data [3];

  assign p_valid = {port3_valid_in, port2_valid_in, port1_valid_in};
  assign p_we    = {port3_we_in, port2_we_in, port1_we_in};
  assign p_addr[0] = port1_addr_in;
  assign p_addr[1] = port2_addr_in;
  assign p_addr[2] = port3_addr_in;
  assign p_data[0] = port1_data_in;
  assign p_data[1] = port2_data_in;
  assign p_data[2] = port3_data_in;

  // Base order as zero-based port indices
  logic [1:0] base [3];

  always_comb begin
    base[0] = 2'd0;
    base[1] = 2'd1;
    base[2] = 2'd2;
    unique case (1'b1)
      (rr_mode && rr_q == RR_P2): begin
        base[0] = 2'd1;
        base[1] = 2'd2;
        base[2] = 2'd0;
      end
      (rr_mode && rr_q == RR_P3): begin
        base[0] = 2'd2;
        base[1] = 2'd0;
        base[2] = 2'd1;
      end
      default: ;
    endcase
  end

  // Valid ports first, then invalid ones, each group in base order
  logic [1:0] ord [3];
  logic [1:0] cnt;

  always_comb begin
    ord[0] = 2'd0;
    ord[1] = 2'd1;
    ord[2] = 2'd2;
    cnt    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (p_valid[base[k]]) begin
        ord[cnt] = base[k];
        cnt      = cnt + 2'd1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!p_valid[base[k]]) begin
        ord[cnt] = base[k];
        cnt      = cnt + 2'd1;
      end
    end
  end

  logic [2:0]            n_valid;
  logic [2:0]            n_we;
  logic [ADDR_WIDTH-1:0] n_addr [3];
  logic [WIDTH-1:0]      n_data [3];
  logic [2:0]            n_wr;
  logic [2:0]            drop;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      n_valid[i] = p_valid[ord[i]];
      n_we[i]    = p_we[ord[i]];
      n_addr[i]  = p_addr[ord[i]];
      n_data[i]  = p_data[ord[i]];
    end
  end

  // A later write loses to any earlier live write of the same address
  assign n_wr    = n_valid & n_we;
  assign drop[0] = 1'b0;
  assign drop[1] = n_wr[1] & n_wr[0]
                 & (n_addr[1] == n_addr[0]);
  assign drop[2] = n_wr[2]
                 & ((n_wr[0] & (n_addr[2] == n_addr[0]))
                  | (n_wr[1] & (n_addr[2] == n_addr[1])));

  always_comb begin
    unique case (rr_q)
      RR_P1:   rr_next = RR_P2;
      RR_P2:   rr_next = RR_P3;
      default: rr_next = RR_P1;
    endcase
  end

  logic [2:0]            s_valid;
  logic [2:0]            s_we;
  logic [ADDR_WIDTH-1:0] s_addr [3];
  logic [WIDTH-1:0]      s_data [3];
  logic [1:0]            s_id   [3];
  logic                  drop_q;

  assign in_ready = out_ready | ~(|s_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid <= '0;
      s_we    <= '0;
      for (int i = 0; i < 3; i++) begin
        s_addr[i] <= '0;
        s_data[i] <= '0;
        s_id[i]   <= 2'(i + 1);
      end
      drop_q <= 1'b0;
      rr_q   <= RR_P1;
    end else begin
      drop_q <= 1'b0;
      if (in_ready) begin
        s_valid <= n_valid & ~drop;
        s_we    <= n_we;
        for (int i = 0; i < 3; i++) begin
          s_addr[i] <= n_addr[i];
          s_data[i] <= n_data[i];
          s_id[i]   <= ord[i] + 2'd1;
        end
        drop_q <= |drop;
        if (rr_mode && |p_valid)
          rr_q <= rr_next;
      end
    end
  end

  assign slot1_valid_out = s_valid[0];
  assign slot1_we_out    = s_we[0];
  assign slot1_addr_out  = s_addr[0];
  assign slot1_data_out  = s_data[0];
  assign slot1_orig_id   = s_id[0];
  assign slot2_valid_out = s_valid[1];
  assign slot2_we_out    = s_we[1];
  assign slot2_addr_out  = s_addr[1];
  assign slot2_data_out  = s_data[1];
  assign slot2_orig_id   = s_id[1];
  assign slot3_valid_out = s_valid[2];
  assign slot3_we_out    = s_we[2];
  assign slot3_addr_out  = s_addr[2];
  assign slot3_data_out  = s_data[2];
  assign slot3_orig_id   = s_id[2];
  assign conflict_drop   = drop_q;

endmodule

// File: tb/tb_port_prioritizer.sv
// Directed bench for port_prioritizer.
// Hand-computed slot orderings, conflicts, stalls and async reset.
module tb_port_prioritizer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rr_mode = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       p1_v = 0, p2_v = 0, p3_v = 0;
  logic       p1_w = 0, p2_w = 0, p3_w = 0;
  logic [3:0] p1_a = 0, p2_a = 0, p3_a = 0;
  logic [7:0] p1_d = 0, p2_d = 0, p3_d = 0;
  logic       s1_v, s2_v, s3_v;
  logic       s1_w, s2_w, s3_w;
  logic [3:0] s1_a, s2_a, s3_a;
  logic [7:0] s1_d, s2_d, s3_d;
  logic [1:0] s1_id, s2_id, s3_id;
  logic       cdrop;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  port_prioritizer #(.WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode),
    .port1_valid_in(p1_v), .port1_we_in(p1_w),
    .port1_addr_in(p1_a), .port1_data_in(p1_d),
    .port2_valid_in(p2_v), .port2_we_in(p2_w),
    .port2_addr_in(p2_a), .port2_data_in(p2_d),
    .port3_valid_in(p3_v), .port3_we_in(p3_w),
    .port3_addr_in(p3_a), .port3_data_in(p3_d),
    .in_ready(in_ready), .out_ready(out_ready),
    .slot1_valid_out(s1_v), .slot1_we_out(s1_w),
    .slot1_addr_out(s1_a), .slot1_data_out(s1_d),
    .slot1_orig_id(s1_id),
    .slot2_valid_out(s2_v), .slot2_we_out(s2_w),
    .slot2_addr_out(s2_a), .slot2_data_out(s2_d),
    .slot2_orig_id(s2_id),
    .slot3_valid_out(s3_v), .slot3_we_out(s3_w),
    .slot3_addr_out(s3_a), .slot3_data_out(s3_d),
    .slot3_orig_id(s3_id),
    .conflict_drop(cdrop)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [2:0] w,
                       input logic [3:0] a1,
                       input logic [3:0] a2,
                       input logic [3:0] a3,
                       input logic [7:0] d1,
                       input logic [7:0] d2,
                       input logic [7:0] d3);
    {p3_v, p2_v, p1_v} = v;
    {p3_w, p2_w, p1_w} = w;
    p1_a = a1; p2_a = a2; p3_a = a3;
    p1_d = d1; p2_d = d2; p3_d = d3;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ids(input string tag,
                         input logic [1:0] i1,
                         input logic [1:0] i2,
                         input logic [1:0] i3);
    chk({tag, ".id1"}, 32'(s1_id), 32'(i1));
    chk({tag, ".id2"}, 32'(s2_id), 32'(i2));
    chk({tag, ".id3"}, 32'(s3_id), 32'(i3));
  endtask

  task automatic chk_vld(input string tag, input logic [2:0] v);
    chk({tag, ".vld"}, 32'({s3_v, s2_v, s1_v}), 32'(v));
  endtask

  initial begin
    // Reset state
    #12;
    chk_vld("rst", 3'b000);
    chk_ids("rst", 2'd1, 2'd2, 2'd3);
    chk("rst.drop", 32'(cdrop), 32'd0);
    chk("rst.rdy", 32'(in_ready), 32'd1);
    chk("rst.addr1", 32'(s1_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three reads, fixed order
    drive(3'b111, 3'b000, 4'd1, 4'd2, 4'd3, 8'h11, 8'h22, 8'h33);
    tick();
    chk_vld("fix", 3'b111);
    chk_ids("fix", 2'd1, 2'd2, 2'd3);
    chk("fix.a1", 32'(s1_a), 32'd1);
    chk("fix.a2", 32'(s2_a), 32'd2);
    chk("fix.a3", 32'(s3_a), 32'd3);
    chk("fix.we", 32'({s3_w, s2_w, s1_w}), 32'd0);

    // Round-robin rotation over four captures
    rr_mode = 1'b1;
    tick();
    chk_ids("rr0", 2'd1, 2'd2, 2'd3);
    tick();
    chk_ids("rr1", 2'd2, 2'd3, 2'd1);
    chk("rr1.a1", 32'(s1_a), 32'd2);
    tick();
    chk_ids("rr2", 2'd3, 2'd1, 2'd2);
    chk("rr2.d1", 32'(s1_d), 32'h33);
    tick();
    chk_ids("rr3", 2'd1, 2'd2, 2'd3);
    rr_mode = 1'b0;

    // Only port 3 valid: compacts to slot1
    drive(3'b100, 3'b000, 4'd0, 4'd0, 4'd5, 8'h00, 8'h00, 8'h55);
    tick();
    chk_vld("p3", 3'b001);
    chk_ids("p3", 2'd3, 2'd1, 2'd2);
    chk("p3.a1", 32'(s1_a), 32'd5);

    // Two-way write conflict
    drive(3'b011, 3'b011, 4'd4, 4'd4, 4'd0, 8'hAA, 8'hBB, 8'h00);
    tick();
    chk_vld("cf2", 3'b001);
    chk_ids("cf2", 2'd1, 2'd2, 2'd3);
    chk("cf2.d1", 32'(s1_d), 32'hAA);
    chk("cf2.d2", 32'(s2_d), 32'hBB);
    chk("cf2.drop", 32'(cdrop), 32'd1);

    // All invalid: stage empties, pulse ends
    drive(3'b000, 3'b000, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00);
    tick();
    chk_vld("empty", 3'b000);
    chk("empty.drop", 32'(cdrop), 32'd0);
    out_ready = 1'b0;
    #1;
    chk("empty.rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Three-way write conflict
    drive(3'b111, 3'b111, 4'd7, 4'd7, 4'd7, 8'h01, 8'h02, 8'h03);
    tick();
    chk_vld("cf3", 3'b001);
    chk("cf3.d1", 32'(s1_d), 32'h01);
    chk("cf3.drop", 32'(cdrop), 32'd1);

    // Read and write to same address both kept
    drive(3'b011, 3'b001, 4'd6, 4'd6, 4'd0, 8'h66, 8'h00, 8'h00);
    tick();
    chk_vld("rw", 3'b011);
    chk("rw.drop", 32'(cdrop), 32'd0);
    chk("rw.we", 32'({s2_w, s1_w}), 32'b01);

    // Load, then stall with changing inputs
    drive(3'b111, 3'b000, 4'd1, 4'd2, 4'd3, 8'h11, 8'h22, 8'h33);
    tick();
    out_ready = 1'b0;
    rr_mode = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(3'b111, 3'b111, 4'(c + 9), 4'(c + 9), 4'd0,
            8'(c), 8'(c + 1), 8'(c + 2));
      tick();
      chk("stl.rdy", 32'(in_ready), 32'd0);
      chk_ids("stl", 2'd1, 2'd2, 2'd3);
      chk("stl.a1", 32'(s1_a), 32'd1);
      chk("stl.drop", 32'(cdrop), 32'd0);
    end

    // Release: rr state still RR_P2, rr_mode now 1
    drive(3'b111, 3'b000, 4'd8, 4'd9, 4'd10, 8'h08, 8'h09, 8'h0A);
    out_ready = 1'b1;
    tick();
    chk_vld("rel", 3'b111);
    chk_ids("rel", 2'd2, 2'd3, 2'd1);
    chk("rel.a1", 32'(s1_a), 32'd9);

    // Async reset mid-cycle while full
    rst_n = 1'b0;
    #1;
    chk_vld("arst", 3'b000);
    chk_ids("arst", 2'd1, 2'd2, 2'd3);
    #1;
    rst_n = 1'b1;
    tick();
    chk_ids("post0", 2'd1, 2'd2, 2'd3);
    chk_vld("post0", 3'b111);
    tick();
    chk_ids("post1", 2'd2, 2'd3, 2'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
